// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers.
//
// Ports:
//   clk      system clock; all state updates on the rising edge
//   rst      synchronous active-high reset
//   multu    start unsigned multiply
//   div      start signed divide
//   divu     start unsigned divide
//   mthi     write rs_data to HI (idle only)
//   mtlo     write rs_data to LO (idle only)
//   rs_data  operand A / dividend / move source
//   rt_data  operand B / divisor
//   hi       product upper half, or remainder
//   lo       product lower half, or quotient
//   busy     operation in flight; stall request
//   done     one-cycle pulse, hi/lo already hold the new result
//
// state | meaning
// IDLE  | waiting for a start strobe or a move
// MUL   | shift-add multiply, one bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIX   | signed divide only: apply quotient/remainder signs
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             multu,
  input  logic             div,
  input  logic             divu,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opa_q;        // multiplicand, or divisor magnitude
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;        // dividend shifts out as quotient shifts in
  logic               div_signed_q;
  logic               neg_quo_q;
  logic               neg_rem_q;

  logic start_div, start_divu, start_mul, start_any;
  logic last_step;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_trial;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   rs_abs, rt_abs;

  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d, done_d;

  // Fixed priority div > divu > multu; only meaningful in IDLE.
  assign start_div  = div;
  assign start_divu = divu & ~div;
  assign start_mul  = multu & ~div & ~divu;
  assign start_any  = div | divu | multu;

  assign last_step = (cnt_q == CNT_W'(1));

  // Multiply step: conditionally add the multiplicand into the upper half,
  // keeping the carry, then shift the whole accumulator right by one.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opa_q : '0)};
  assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step on a WIDTH+1 bit partial remainder; bit WIDTH of
  // the trial result is the borrow and decides restore vs. keep.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_trial = rem_shift - {1'b0, opa_q};
  assign rem_step  = rem_trial[WIDTH] ? rem_shift[WIDTH-1:0] : rem_trial[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], ~rem_trial[WIDTH]};

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  assign rs_abs = rs_data[WIDTH-1] ? (-rs_data) : rs_data;
  assign rt_abs = rt_data[WIDTH-1] ? (-rt_data) : rt_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_div | start_divu) state_d = DIV;
        else if (start_mul)         state_d = MUL;
      end
      MUL: if (last_step) state_d = IDLE;
      DIV: if (last_step) state_d = div_signed_q ? FIX : IDLE;
      FIX: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for hi/lo/busy/done
  always_comb begin
    hi_d   = hi;
    lo_d   = lo;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!start_any) begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      MUL: begin
        if (last_step) begin
          hi_d   = acc_step[2*WIDTH-1:WIDTH];
          lo_d   = acc_step[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      DIV: begin
        if (last_step && !div_signed_q) begin
          hi_d   = rem_step;
          lo_d   = quo_step;
          done_d = 1'b1;
        end
      end
      FIX: begin
        hi_d   = neg_rem_q ? (-rem_q) : rem_q;
        lo_d   = neg_quo_q ? (-quo_q) : quo_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Result, status and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi           <= '0;
      lo           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      opa_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      div_signed_q <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
    end else begin
      hi   <= hi_d;
      lo   <= lo_d;
      busy <= busy_d;
      done <= done_d;
      case (state_q)
        IDLE: begin
          if (start_div) begin
            quo_q        <= rs_abs;
            opa_q        <= rt_abs;
            rem_q        <= '0;
            div_signed_q <= 1'b1;
            neg_quo_q    <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
            neg_rem_q    <= rs_data[WIDTH-1];
            cnt_q        <= CNT_W'(WIDTH);
          end else if (start_divu) begin
            quo_q        <= rs_data;
            opa_q        <= rt_data;
            rem_q        <= '0;
            div_signed_q <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            cnt_q        <= CNT_W'(WIDTH);
          end else if (start_mul) begin
            acc_q <= {{WIDTH{1'b0}}, rt_data};
            opa_q <= rs_data;
            cnt_q <= CNT_W'(WIDTH);
          end
        end
        MUL: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        DIV: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        multu = 1'b0, div = 1'b0, divu = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .multu   (multu),
    .div     (div),
    .divu    (divu),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive strobes for one rising edge starting at a falling edge.
  task automatic issue(input logic s_mul, input logic s_div, input logic s_divu,
                       input logic s_hi, input logic s_lo,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    multu = s_mul; div = s_div; divu = s_divu; mthi = s_hi; mtlo = s_lo;
    rs_data = a; rt_data = b;
    @(posedge clk);
    #1;
    multu = 1'b0; div = 1'b0; divu = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  // Count remaining busy cycles, then check the done pulse and results.
  task automatic wait_done(input string tag, input int exp_busy,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 32'(n), 32'(exp_busy));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    @(negedge clk);
    check({tag, " done_pulse_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);

    issue(1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", 32, 32'hFFFFFFFE, 32'h00000001);

    issue(0, 0, 1, 0, 0, 32'd100, 32'd7);
    wait_done("divu_100_7", 32, 32'd2, 32'd14);

    issue(0, 1, 0, 0, 0, 32'hFFFFFFF9, 32'd2);
    wait_done("div_m7_2", 33, 32'hFFFFFFFF, 32'hFFFFFFFD);

    issue(0, 1, 0, 0, 0, 32'hFFFFFFF0, 32'd0);
    wait_done("div_by_zero", 33, 32'hFFFFFFF0, 32'h00000001);

    issue(0, 0, 1, 0, 0, 32'd5, 32'd0);
    wait_done("divu_by_zero", 32, 32'd5, 32'hFFFFFFFF);

    issue(0, 1, 0, 0, 0, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_overflow", 33, 32'h0, 32'h80000000);

    // mthi+mtlo together in IDLE
    issue(0, 0, 0, 1, 1, 32'h12345678, 32'h0);
    check("mov hi", hi, 32'h12345678);
    check("mov lo", lo, 32'h12345678);
    @(negedge clk);
    check("mov done", 32'(done), 32'd0);
    check("mov busy", 32'(busy), 32'd0);

    // multu wins over simultaneous moves
    issue(1, 0, 0, 1, 1, 32'd3, 32'd5);
    check("mov_vs_start hi", hi, 32'h12345678);
    check("mov_vs_start lo", lo, 32'h12345678);
    wait_done("multu_3_5", 32, 32'd0, 32'd15);

    // moves while busy are ignored
    issue(0, 0, 1, 0, 0, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    issue(0, 0, 0, 1, 1, 32'hAAAA5555, 32'h0);
    check("mov_busy hi", hi, 32'd0);
    check("mov_busy lo", lo, 32'd15);
    wait_done("divu_after_mov", 29, 32'd2, 32'd14);

    // div beats multu; a divu at busy cycle 5 is ignored
    issue(1, 1, 0, 0, 0, 32'hFFFFFFF9, 32'd2);
    repeat (4) @(negedge clk);
    issue(0, 0, 1, 0, 0, 32'd100, 32'd7);
    wait_done("div_prio", 28, 32'hFFFFFFFF, 32'hFFFFFFFD);

    // reset mid-multiply at busy cycle 10
    issue(1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst hi", hi, 32'h0);
    check("midrst lo", lo, 32'h0);
    issue(0, 0, 1, 0, 0, 32'd100, 32'd7);
    wait_done("divu_after_rst", 32, 32'd2, 32'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
